// File: rtl/mem_arbiter_if.sv
// mem_arbiter bus: fetch port, data port and memory pins.
// slave = arbiter side, master = pipeline/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_ack;
  logic [15:0]           i_rdata;
  logic                  d_req;
  logic                  d_wr;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [15:0]           d_wdata;
  logic                  d_ack;
  logic [15:0]           d_rdata;
  logic                  mem_enable;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_data_in;
  logic [15:0]           mem_data_out;

  modport slave (
    input  i_req, i_addr, d_req, d_wr,
    input  d_addr, d_wdata, mem_data_out,
    output i_ack, i_rdata, d_ack, d_rdata,
    output mem_enable, mem_wr, mem_addr,
    output mem_data_in
  );

  modport master (
    output i_req, i_addr, d_req, d_wr,
    output d_addr, d_wdata, mem_data_out,
    input  i_ack, i_rdata, d_ack, d_rdata,
    input  mem_enable, mem_wr, mem_addr,
    input  mem_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin fetch/data arbiter with fixed access latency.
// Ports: clk, rst_n, bus (mem_arbiter_if.slave), busy.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE, WAIT, ACCESS, RESP
  } state_t;

  localparam logic [3:0] CNT_INIT =
    (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;

  // port/last_grant: 1 = data port, 0 = fetch port
  logic port, last_grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic wr_q;
  logic [15:0] wdata_q;
  logic [15:0] i_rdata_q, d_rdata_q;

  logic gnt, gnt_d, access;

  // on a tie the port that did not win last time goes
  always_comb begin
    gnt   = bus.i_req | bus.d_req;
    gnt_d = bus.d_req & (~bus.i_req | ~last_grant);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (gnt) begin
          if (LATENCY > 1) begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end else begin
            state_nx = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nx = ACCESS;
        else cnt_nx = cnt - 4'd1;
      end
      ACCESS: state_nx = RESP;
      RESP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port       <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (state == IDLE && gnt) begin
        port       <= gnt_d;
        last_grant <= gnt_d;
        addr_q     <= gnt_d ? bus.d_addr : bus.i_addr;
        wr_q       <= gnt_d & bus.d_wr;
        wdata_q    <= gnt_d ? bus.d_wdata : 16'h0;
      end
      if (state == ACCESS && !wr_q) begin
        if (port) d_rdata_q <= bus.mem_data_out;
        else      i_rdata_q <= bus.mem_data_out;
      end
    end
  end

  // memory pins decode straight from state so reset
  // kills an in-flight access immediately
  assign access = (state == ACCESS);

  always_comb begin
    bus.mem_enable  = access;
    bus.mem_wr      = access & wr_q;
    bus.mem_addr    = access ? {addr_q[ADDR_WIDTH-1:1], 1'b0}
                             : addr_q;
    bus.mem_data_in = wdata_q;
    bus.i_ack       = (state == RESP) & ~port;
    bus.d_ack       = (state == RESP) & port;
    bus.i_rdata     = i_rdata_q;
    bus.d_rdata     = d_rdata_q;
    busy            = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: LATENCY 4 and LATENCY 1 instances,
// transaction-level model, directed stimulus.
module tb_mem_arbiter;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] ireq = '0;
  logic [1:0] dreq = '0;
  logic [1:0] dwr = '0;
  logic [15:0] iaddr [2] = '{default: 16'h0};
  logic [15:0] daddr [2] = '{default: 16'h0};
  logic [15:0] dwdata [2] = '{default: 16'h0};
  logic [1:0] iack, dack, busy, en;
  logic [15:0] irdata [2];
  logic [15:0] drdata [2];
  logic [15:0] maddr [2];

  int pass_n = 0;
  int total_n = 0;

  for (genvar k = 0; k < 2; k++) begin : cfg
    localparam int LAT = (k == 0) ? 4 : 1;

    mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
    logic bsy;

    mem_arbiter #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .busy(bsy)
    );

    assign bus.i_req   = ireq[k];
    assign bus.i_addr  = iaddr[k];
    assign bus.d_req   = dreq[k];
    assign bus.d_wr    = dwr[k];
    assign bus.d_addr  = daddr[k];
    assign bus.d_wdata = dwdata[k];
    assign iack[k]     = bus.i_ack;
    assign dack[k]     = bus.d_ack;
    assign busy[k]     = bsy;
    assign en[k]       = bus.mem_enable;
    assign irdata[k]   = bus.i_rdata;
    assign drdata[k]   = bus.d_rdata;
    assign maddr[k]    = bus.mem_addr;

    // memory device: words 0..15 preloaded, rest zero
    logic [15:0] dev [256];
    bit dld = 1'b0;
    assign bus.mem_data_out = dev[bus.mem_addr[8:1]];
    always @(posedge clk) begin
      if (!dld) begin
        for (int j = 0; j < 256; j++)
          dev[j] <= (j < 16) ? 16'hC000 + 16'(j) : 16'h0;
        dld <= 1'b1;
      end else if (bus.mem_enable && bus.mem_wr) begin
        dev[bus.mem_addr[8:1]] <= bus.mem_data_in;
      end
    end

    // transaction model: grant at edge g, access in the cycle
    // before edge g+LAT, ack in the cycle after it, done at g+LAT+1
    logic [15:0] mm [256];
    bit mld = 1'b0;
    int n = 0;
    int g = 0;
    bit act = 1'b0;
    bit ap = 1'b0;
    bit aw = 1'b0;
    bit lg = 1'b1;
    logic [15:0] aa = '0;
    logic [15:0] ad = '0;
    logic [15:0] ei = '0;
    logic [15:0] ed = '0;

    always @(posedge clk or negedge rst_n) begin
      if (!mld) begin
        for (int j = 0; j < 256; j++)
          mm[j] = (j < 16) ? 16'hC000 + 16'(j) : 16'h0;
        mld = 1'b1;
      end
      if (!rst_n) begin
        act = 1'b0;
        lg  = 1'b1;
        aa  = '0;
        ad  = '0;
        aw  = 1'b0;
        ei  = '0;
        ed  = '0;
      end else begin
        n++;
        if (act) begin
          if (n == g + LAT) begin
            if (aw)      mm[aa[8:1]] = ad;
            else if (ap) ed = mm[aa[8:1]];
            else         ei = mm[aa[8:1]];
          end
          if (n == g + LAT + 1) act = 1'b0;
        end else if (ireq[k] || dreq[k]) begin
          if (ireq[k] && dreq[k]) ap = !lg;
          else                    ap = dreq[k];
          lg  = ap;
          act = 1'b1;
          g   = n;
          aa  = ap ? daddr[k] : iaddr[k];
          aw  = ap && dwr[k];
          ad  = ap ? dwdata[k] : 16'h0;
        end
      end
    end

    logic acc, ackc;
    logic [68:0] want, got;
    assign acc  = act && (n == g + LAT - 1);
    assign ackc = act && (n == g + LAT);
    assign want = {act, acc, acc && aw, ackc && !ap, ackc && ap,
                   acc ? {aa[15:1], 1'b0} : aa, ei, ed,
                   (acc && aw) ? ad : 16'h0};
    assign got  = {bsy, bus.mem_enable, bus.mem_wr,
                   bus.i_ack, bus.d_ack, bus.mem_addr,
                   bus.i_rdata, bus.d_rdata,
                   bus.mem_wr ? bus.mem_data_in : 16'h0};
  end

  task automatic mchk(string nm, logic [68:0] g, logic [68:0] w);
    total_n++;
    if (g === w) pass_n++;
    else $display("FAIL %s @%0t: got %h want %h", nm, $time, g, w);
  endtask

  task automatic schk(string nm, int g, int w);
    total_n++;
    if (g === w) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, g, w);
  endtask

  task automatic tick();
    @(negedge clk);
    mchk("lat4_model", cfg[0].got, cfg[0].want);
    mchk("lat1_model", cfg[1].got, cfg[1].want);
  endtask

  task automatic reset_pulse();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic xact(input int k, input bit dp, input bit w,
                      input logic [15:0] a, input logic [15:0] wd,
                      output int lat, output int ens, output int ec,
                      output logic [15:0] rd, output logic [15:0] ea);
    int c;
    bit done;
    c = 0;
    done = 1'b0;
    lat = 0;
    ens = 0;
    ec = 0;
    rd = '0;
    ea = '0;
    tick();
    if (dp) begin
      dreq[k] = 1'b1;
      dwr[k] = w;
      daddr[k] = a;
      dwdata[k] = wd;
    end else begin
      ireq[k] = 1'b1;
      iaddr[k] = a;
    end
    while (!done && c < 40) begin
      tick();
      c++;
      if (en[k]) begin
        ens++;
        ec = c;
        ea = maddr[k];
      end
      if (dp ? dack[k] : iack[k]) begin
        done = 1'b1;
        lat = c;
        rd = dp ? drdata[k] : irdata[k];
      end
    end
    if (dp) dreq[k] = 1'b0;
    else    ireq[k] = 1'b0;
    if (!done) schk("xact_timeout", 0, 1);
  endtask

  initial begin
    int lat, ens, ec, c, first, both, nack, pat, idle, span;
    bit gi, gd, started, ack_seen;
    logic [15:0] rd, ea, ird, drd;

    #1 rst_n = 1'b0;
    tick();
    tick();
    schk("rst_flags", int'({busy, iack, dack, en}), 0);
    schk("rst_maddr", int'(maddr[0]), 0);
    schk("rst_i_rdata", int'(irdata[0]), 0);
    schk("rst_d_rdata", int'(drdata[0]), 0);
    rst_n = 1'b1;

    xact(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, lat, ens, ec, rd, ea);
    schk("wr_ack_cycle", lat, 5);
    schk("wr_enable_cycles", ens, 1);

    xact(0, 1'b1, 1'b0, 16'h0010, 16'h0, lat, ens, ec, rd, ea);
    schk("rd_ack_cycle", lat, 5);
    schk("rd_enable_cycles", ens, 1);
    schk("rd_beef", int'(rd), 'hBEEF);

    xact(0, 1'b1, 1'b1, 16'h0021, 16'h1234, lat, ens, ec, rd, ea);
    schk("wr_addr_aligned", int'(ea), 'h0020);

    xact(0, 1'b1, 1'b0, 16'h0020, 16'h0, lat, ens, ec, rd, ea);
    schk("rd_1234", int'(rd), 'h1234);

    reset_pulse();
    tick();
    ireq[0] = 1'b1;
    iaddr[0] = 16'h0002;
    dreq[0] = 1'b1;
    dwr[0] = 1'b0;
    daddr[0] = 16'h0020;
    first = -1;
    both = 0;
    c = 0;
    gi = 1'b0;
    gd = 1'b0;
    ird = '0;
    drd = '0;
    while ((!gi || !gd) && c < 60) begin
      tick();
      c++;
      if (iack[0] && dack[0]) both = 1;
      if (iack[0]) begin
        gi = 1'b1;
        if (first < 0) first = 0;
        ird = irdata[0];
        ireq[0] = 1'b0;
      end
      if (dack[0]) begin
        gd = 1'b1;
        if (first < 0) first = 1;
        drd = drdata[0];
        dreq[0] = 1'b0;
      end
    end
    ireq[0] = 1'b0;
    dreq[0] = 1'b0;
    schk("tie_done", int'(gi && gd), 1);
    schk("tie_fetch_first", first, 0);
    schk("tie_no_double_ack", both, 0);
    schk("tie_i_rdata", int'(ird), 'hC001);
    schk("tie_d_rdata", int'(drd), 'h1234);

    tick();
    ireq[0] = 1'b1;
    iaddr[0] = 16'h0006;
    dreq[0] = 1'b1;
    dwr[0] = 1'b0;
    daddr[0] = 16'h0010;
    nack = 0;
    pat = 0;
    c = 0;
    idle = 0;
    span = 0;
    started = 1'b0;
    while (nack < 6 && c < 100) begin
      tick();
      c++;
      if (started) span++;
      if (started && !busy[0]) idle++;
      if (iack[0] || dack[0]) begin
        pat = pat * 2 + int'(dack[0]);
        if (iack[0] && dack[0]) pat = pat + 1000;
        nack++;
        started = 1'b1;
      end
    end
    ireq[0] = 1'b0;
    dreq[0] = 1'b0;
    schk("stream_order_IDIDID", pat, 'b010101);
    schk("stream_span", span, 30);
    schk("stream_idle_cycles", idle, 5);

    xact(1, 1'b0, 1'b0, 16'h0004, 16'h0, lat, ens, ec, rd, ea);
    schk("lat1_enable_cycle", ec, 1);
    schk("lat1_ack_cycle", lat, 2);
    schk("lat1_rdata", int'(rd), 'hC002);

    tick();
    dreq[0] = 1'b1;
    dwr[0] = 1'b1;
    daddr[0] = 16'h0040;
    dwdata[0] = 16'h5555;
    c = 0;
    while (!en[0] && c < 20) begin
      tick();
      c++;
    end
    schk("abort_reached_access", int'(en[0]), 1);
    #2 rst_n = 1'b0;
    dreq[0] = 1'b0;
    #1;
    schk("abort_enable_drop", int'(en[0]), 0);
    schk("abort_busy", int'(busy[0]), 0);
    schk("abort_maddr", int'(maddr[0]), 0);
    schk("abort_d_rdata", int'(drdata[0]), 0);
    ack_seen = 1'b0;
    repeat (2) begin
      tick();
      if (iack[0] || dack[0]) ack_seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (8) begin
      tick();
      if (iack[0] || dack[0]) ack_seen = 1'b1;
    end
    schk("abort_no_ack", int'(ack_seen), 0);
    xact(0, 1'b1, 1'b0, 16'h0040, 16'h0, lat, ens, ec, rd, ea);
    schk("abort_no_write", int'(rd), 0);
    schk("abort_read_cycle", lat, 5);

    tick();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
